// File: rtl/dp_mem_responder.sv
// Memory-side responder for the datapath request/hit protocol: one single-port word RAM
// with fixed access latency. Define DP_MEM_IBUF_EN to add a one-entry instruction buffer.
module dp_mem_responder #(
    parameter int unsigned AW  = 10,
    parameter int unsigned LAT = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic        dhit,
    output logic [31:0] dmemload,
    input  logic        halt,
    input  logic        ld_en,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data
);
    localparam int unsigned DW    = 32;
    localparam int unsigned CW    = 4;
    localparam int unsigned DEPTH = 1 << AW;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    typedef enum logic [1:0] {K_FETCH, K_LOAD, K_STORE} kind_t;

    state_t        state;
    kind_t         kind_q;
    kind_t         new_kind_c;
    kind_t         cur_kind_c;
    logic [CW-1:0] cnt;
    logic [AW-1:0] idx_q;
    logic [AW-1:0] iidx_c;
    logic [AW-1:0] didx_c;
    logic [AW-1:0] ld_idx_c;
    logic [AW-1:0] new_idx_c;
    logic [AW-1:0] cur_idx_c;
    logic [DW-1:0] wdata_q;
    logic          ihit_q;
    logic          dhit_q;
    logic [DW-1:0] imemload_q;
    logic [DW-1:0] dmemload_q;
    logic [DW-1:0] mem [DEPTH];
    logic          accept_c;
    logic          go_resp_c;
    logic          pre_we_c;
    logic          st_we_c;
    logic          ibuf_hit_c;
    logic          unused_addr_bits;

    assign iidx_c   = imemaddr[AW+1:2];
    assign didx_c   = dmemaddr[AW+1:2];
    assign ld_idx_c = ld_addr[AW+1:2];

    // Byte offset and bits above the RAM index are don't-care (addresses alias).
    assign unused_addr_bits = ^{imemaddr[31:AW+2], imemaddr[1:0],
                                dmemaddr[31:AW+2], dmemaddr[1:0],
                                ld_addr[31:AW+2],  ld_addr[1:0]};

    // Request priority: store > load > fetch; REN+WEN together counts as a store.
    always_comb begin
        new_kind_c = K_FETCH;
        new_idx_c  = iidx_c;
        if (dmemWEN) begin
            new_kind_c = K_STORE;
            new_idx_c  = didx_c;
        end else if (dmemREN) begin
            new_kind_c = K_LOAD;
            new_idx_c  = didx_c;
        end
    end

    // With LAT = 1 the response is launched on the accepting edge, before kind/idx are latched.
    assign cur_kind_c = (state == IDLE) ? new_kind_c : kind_q;
    assign cur_idx_c  = (state == IDLE) ? new_idx_c  : idx_q;

    assign accept_c  = (state == IDLE) && !ld_en && !halt && !ibuf_hit_c
                       && (imemREN || dmemREN || dmemWEN);
    assign go_resp_c = (accept_c && (LAT == 1)) || ((state == BUSY) && (cnt <= CW'(1)));
    assign pre_we_c  = (state == IDLE) && ld_en && !RST;
    assign st_we_c   = (state == RESP) && (kind_q == K_STORE) && !RST;

`ifdef DP_MEM_IBUF_EN
    logic          buf_valid;
    logic [AW-1:0] buf_idx;
    logic [DW-1:0] buf_word;

    assign ibuf_hit_c = (state == IDLE) && !ld_en && !halt && imemREN && !dmemREN && !dmemWEN
                        && buf_valid && (buf_idx == iidx_c);

    // Buffer refills on every RAM fetch and drops on any write to the buffered word.
    always_ff @(posedge CLK) begin
        if (RST) begin
            buf_valid <= 1'b0;
            buf_idx   <= '0;
            buf_word  <= '0;
        end else if (go_resp_c && (cur_kind_c == K_FETCH)) begin
            buf_valid <= 1'b1;
            buf_idx   <= cur_idx_c;
            buf_word  <= mem[cur_idx_c];
        end else if ((pre_we_c && (ld_idx_c == buf_idx)) || (st_we_c && (idx_q == buf_idx))) begin
            buf_valid <= 1'b0;
        end
    end

    assign ihit     = ihit_q | ibuf_hit_c;
    assign imemload = ibuf_hit_c ? buf_word : imemload_q;
`else
    assign ibuf_hit_c = 1'b0;
    assign ihit       = ihit_q;
    assign imemload   = imemload_q;
`endif

    assign dhit     = dhit_q;
    assign dmemload = dmemload_q;

    // RAM contents survive reset; writes are suppressed while RST is high.
    always_ff @(posedge CLK) begin
        if (pre_we_c) begin
            mem[ld_idx_c] <= ld_data;
        end else if (st_we_c) begin
            mem[idx_q] <= wdata_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            cnt        <= '0;
            kind_q     <= K_FETCH;
            idx_q      <= '0;
            wdata_q    <= '0;
            ihit_q     <= 1'b0;
            dhit_q     <= 1'b0;
            imemload_q <= '0;
            dmemload_q <= '0;
        end else begin
            ihit_q <= 1'b0;
            dhit_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        kind_q  <= new_kind_c;
                        idx_q   <= new_idx_c;
                        wdata_q <= dmemstore;
                        cnt     <= CW'(LAT - 1);
                        if (LAT == 1) begin
                            state <= RESP;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    cnt <= cnt - CW'(1);
                    if (cnt <= CW'(1)) begin
                        state <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
            // Hits are registered so they are visible for the whole RESP cycle.
            if (go_resp_c) begin
                if (cur_kind_c == K_FETCH) begin
                    ihit_q     <= 1'b1;
                    imemload_q <= mem[cur_idx_c];
                end else begin
                    dhit_q <= 1'b1;
                    if (cur_kind_c == K_LOAD) begin
                        dmemload_q <= mem[cur_idx_c];
                    end
                end
            end
`ifdef DP_MEM_IBUF_EN
            if (ibuf_hit_c) begin
                imemload_q <= buf_word;
            end
`endif
        end
    end
endmodule

// File: tb/tb_dp_mem_responder.sv
// Bench for dp_mem_responder: directed scenarios plus randomized accesses checked
// against a word-array model of the memory.
module tb_dp_mem_responder;
    localparam int unsigned AW    = 10;
    localparam int unsigned LAT   = 2;
    localparam int unsigned DEPTH = 1 << AW;

    logic        CLK = 1'b0;
    logic        RST;
    logic        imemREN, dmemREN, dmemWEN, halt, ld_en;
    logic [31:0] imemaddr, dmemaddr, dmemstore, ld_addr, ld_data;
    logic        ihit, dhit;
    logic [31:0] imemload, dmemload;
    logic        imemREN1, ihit1, dhit1;
    logic [31:0] imemload1, dmemload1;

    int tests = 0;
    int fails = 0;

    logic [31:0] ref_mem [DEPTH];
    bit          ref_buf_v;
    int          ref_buf_idx;
    logic [31:0] last_dload;

    always #5 CLK = ~CLK;

    dp_mem_responder #(.AW(AW), .LAT(LAT)) u_dut (
        .CLK(CLK), .RST(RST),
        .imemREN(imemREN), .imemaddr(imemaddr), .ihit(ihit), .imemload(imemload),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .dhit(dhit), .dmemload(dmemload), .halt(halt),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    dp_mem_responder #(.AW(AW), .LAT(1)) u_dut_lat1 (
        .CLK(CLK), .RST(RST),
        .imemREN(imemREN1), .imemaddr(32'h0000_0040), .ihit(ihit1), .imemload(imemload1),
        .dmemREN(1'b0), .dmemWEN(1'b0), .dmemaddr(32'h0), .dmemstore(32'h0),
        .dhit(dhit1), .dmemload(dmemload1), .halt(1'b0),
        .ld_en(1'b0), .ld_addr(32'h0), .ld_data(32'h0)
    );

    function automatic int idx_of(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(posedge CLK); #1;
        ld_en   = 1'b0;
        ld_addr = $urandom;
        ref_mem[idx_of(a)] = d;
        if (ref_buf_v && ref_buf_idx == idx_of(a)) ref_buf_v = 1'b0;
    endtask

    // kind: 0 fetch, 1 load, 2 store. Request is dropped and scrambled right after acceptance.
    task automatic access(input int kind, input logic [31:0] a, input logic [31:0] d, input string tag);
        int exp_lat;
        bit got;
        int i;
        exp_lat = int'(LAT);
`ifdef DP_MEM_IBUF_EN
        if (kind == 0 && ref_buf_v && ref_buf_idx == idx_of(a)) exp_lat = 0;
`endif
        i = idx_of(a);
        imemREN   = (kind == 0);
        dmemREN   = (kind == 1);
        dmemWEN   = (kind == 2);
        imemaddr  = a;
        dmemaddr  = a;
        dmemstore = d;
        got = 1'b0;
        for (int k = 0; k <= int'(LAT) + 3 && !got; k++) begin
            @(negedge CLK);
            if (ihit || dhit) begin
                got = 1'b1;
                check({tag, "_lat"}, 32'(k), 32'(exp_lat));
                check({tag, "_ihit"}, 32'(ihit), 32'(kind == 0));
                check({tag, "_dhit"}, 32'(dhit), 32'(kind != 0));
                if (kind == 0) begin
                    check({tag, "_iload"}, imemload, ref_mem[i]);
                    ref_buf_v   = 1'b1;
                    ref_buf_idx = i;
                end else if (kind == 1) begin
                    last_dload = ref_mem[i];
                    check({tag, "_dload"}, dmemload, last_dload);
                end else begin
                    check({tag, "_dhold"}, dmemload, last_dload);
                    ref_mem[i] = d;
                    if (ref_buf_v && ref_buf_idx == i) ref_buf_v = 1'b0;
                end
            end
            @(posedge CLK); #1;
            if (k == 0) begin
                imemREN   = 1'b0;
                dmemREN   = 1'b0;
                dmemWEN   = 1'b0;
                imemaddr  = $urandom;
                dmemaddr  = $urandom;
                dmemstore = $urandom;
            end
        end
        if (!got) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int          r;
        RST = 1'b1; imemREN = 0; dmemREN = 0; dmemWEN = 0; halt = 0; ld_en = 0;
        imemaddr = 0; dmemaddr = 0; dmemstore = 0; ld_addr = 0; ld_data = 0; imemREN1 = 0;
        ref_buf_v = 1'b0; ref_buf_idx = 0; last_dload = 32'h0;

        // Reset held two cycles: all outputs zero.
        @(posedge CLK); #1;
        for (int k = 0; k < 2; k++) begin
            @(negedge CLK);
            check("rst_ihit", 32'(ihit), 32'd0);
            check("rst_dhit", 32'(dhit), 32'd0);
            check("rst_iload", imemload, 32'd0);
            check("rst_dload", dmemload, 32'd0);
            @(posedge CLK); #1;
        end
        RST = 1'b0;

        for (int k = 0; k < 32; k++) preload(32'(k) << 2, $urandom);
        preload(32'h40, 32'hDEAD_BEEF);
        access(0, 32'h40, 32'h0, "fetch40");

        // Store and fetch requested together: store first, fetch afterwards.
        imemREN = 1'b1; imemaddr = 32'h7C;
        dmemWEN = 1'b1; dmemaddr = 32'h10; dmemstore = 32'h1234_5678;
        for (int k = 0; k <= 2 * int'(LAT) + 2; k++) begin
            @(negedge CLK);
            check("prio_dhit", 32'(dhit), 32'(k == int'(LAT)));
            check("prio_ihit", 32'(ihit), 32'(k == 2 * int'(LAT) + 1));
            if (k == int'(LAT)) ref_mem[4] = 32'h1234_5678;
            if (k == 2 * int'(LAT) + 1) begin
                check("prio_iload", imemload, ref_mem[31]);
                ref_buf_v = 1'b1; ref_buf_idx = 31;
            end
            @(posedge CLK); #1;
            if (k == 0) dmemWEN = 1'b0;
            if (k == int'(LAT) + 1) imemREN = 1'b0;
        end
        access(1, 32'h10, 32'h0, "prio_load");
        check("prio_value", last_dload, 32'h1234_5678);

        // Aliasing: 0x1002 maps to word 0 with AW = 10.
        access(2, 32'h1002, 32'hA5A5_A5A5, "alias_st");
        access(1, 32'h0000, 32'h0, "alias_ld");
        check("alias_value", last_dload, 32'hA5A5_A5A5);

        // Halt raised while busy: one hit, then nothing while the request stays up.
        dmemREN = 1'b1; dmemaddr = 32'h20;
        for (int k = 0; k <= 8; k++) begin
            @(negedge CLK);
            check("halt_dhit", 32'(dhit), 32'(k == int'(LAT)));
            check("halt_ihit", 32'(ihit), 32'd0);
            if (k == int'(LAT)) begin
                last_dload = ref_mem[8];
                check("halt_dload", dmemload, last_dload);
            end
            @(posedge CLK); #1;
            if (k == 0) halt = 1'b1;
        end
        halt = 1'b0; dmemREN = 1'b0;

        // Reset during a store: no hit, outputs cleared, target word untouched.
        dmemWEN = 1'b1; dmemaddr = 32'h24; dmemstore = ~ref_mem[9];
        @(posedge CLK); #1;
        dmemWEN = 1'b0; RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0; ref_buf_v = 1'b0; last_dload = 32'h0;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            check("rmid_ihit", 32'(ihit), 32'd0);
            check("rmid_dhit", 32'(dhit), 32'd0);
            check("rmid_iload", imemload, 32'd0);
            check("rmid_dload", dmemload, 32'd0);
            @(posedge CLK); #1;
        end
        access(1, 32'h24, 32'h0, "rmid_ld");

        // Fetch twice, store, fetch again (instruction buffer path when enabled).
        access(0, 32'h40, 32'h0, "ibuf_f1");
        access(0, 32'h40, 32'h0, "ibuf_f2");
        access(2, 32'h40, 32'hC0DE_0001, "ibuf_st");
        access(0, 32'h40, 32'h0, "ibuf_f3");

        // Randomized mix of preloads, fetches, loads and stores with aliased upper bits.
        for (int n = 0; n < 80; n++) begin
            a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 31)) << 2)
                | 32'($urandom_range(0, 3));
            r = int'($urandom_range(0, 9));
            if (r == 0) preload(a, $urandom);
            else access(int'($urandom_range(0, 2)), a, $urandom, "rand");
        end

        // LAT = 1 instance with fetch held high.
        imemREN1 = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge CLK);
`ifdef DP_MEM_IBUF_EN
            check("lat1_ihit", 32'(ihit1), 32'(k >= 1));
`else
            check("lat1_ihit", 32'(ihit1), 32'(k % 2 == 1));
`endif
            check("lat1_dhit", 32'(dhit1), 32'd0);
            @(posedge CLK); #1;
        end
        imemREN1 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
